// File: rtl/fsm_core_pkg.sv
// Shared types and constants for the fsm_core arbiter slice: arbiter
// state encoding and the 2-bit state codes reported by the shared core.
package fsm_core_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic [1:0] CORE_S0 = 2'b00;
   localparam logic [1:0] CORE_S1 = 2'b01;
   localparam logic [1:0] CORE_S2 = 2'b10;
   localparam logic [1:0] CORE_S3 = 2'b11;

   // The core cannot leave this state on its own; only a reset frees it.
   localparam logic [1:0] TRAP_STATE = CORE_S1;

endpackage

// File: rtl/fsm_core_arbiter_rr_pick.sv
// Combinational round-robin search: first requester with req high,
// scanning upward from rr_ptr+1 and wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] pick,
   output logic [PW-1:0]   pick_idx
);

   logic          found;
   int            cand;
   logic [PW-1:0] cidx;

   // Scan NREQ candidates after the pointer, keep only the first hit.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      cand     = 0;
      cidx     = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = int'(rr_ptr) + off;
         // Explicit wrap so non-power-of-two NREQ never indexes past the end.
         if (cand >= NREQ) cand = cand - NREQ;
         cidx = PW'(cand);
         if (!found && req[cidx]) begin
            found      = 1'b1;
            pick[cidx] = 1'b1;
            pick_idx   = cidx;
         end
      end
   end

endmodule

// File: rtl/fsm_core_arbiter.sv
// Round-robin arbiter sharing one fsm_2-style core between NREQ requesters,
// with a trap monitor that resets the core when it sits in TRAP_STATE too long.
module fsm_core_arbiter
   import fsm_core_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int HOLD_MAX   = 8,
   parameter int TRAP_LIMIT = 16,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_abcd,
   input  logic [1:0]        core_out,
   input  logic              trap_clr,
   output logic [NREQ-1:0]   gnt,
   output logic [3:0]        core_abcd,
   output logic              core_rst,
   output logic              trap_flag,
   output logic              busy
);

   localparam int PW = $clog2(NREQ);
   localparam int HW = $clog2(HOLD_MAX);
   localparam int TW = $clog2(TRAP_LIMIT + 1);
   localparam int RW = $clog2(RST_CYCLES + 1);

   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] g;
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] trap_cnt;
   logic [RW-1:0] rcv_cnt;

   logic [NREQ-1:0] pick;
   logic [PW-1:0]   pick_idx;
   logic            trap_hit;
   logic            release_now;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   // The trap fires on the edge where the consecutive count would reach TRAP_LIMIT.
   assign trap_hit = (state != RECOVER) && (core_out == TRAP_STATE) &&
                     (trap_cnt >= TW'(TRAP_LIMIT - 1));

   // Owner gives up the core when it drops req or has used its full hold window.
   assign release_now = !req[g] || (hold_cnt == HW'(HOLD_MAX - 1));

   // Arbiter FSM, trap monitor and all registered core-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RECOVER;
         gnt       <= '0;
         core_abcd <= '0;
         core_rst  <= 1'b1;
         trap_flag <= 1'b0;
         busy      <= 1'b1;
         rr_ptr    <= PW'(NREQ - 1);
         g         <= '0;
         hold_cnt  <= '0;
         trap_cnt  <= '0;
         rcv_cnt   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (trap_hit)      trap_flag <= 1'b1;
         else if (trap_clr) trap_flag <= 1'b0;

         if (state != RECOVER) begin
            if (core_out == TRAP_STATE) begin
               if (trap_cnt != TW'(TRAP_LIMIT)) trap_cnt <= trap_cnt + 1'b1;
            end else begin
               trap_cnt <= '0;
            end
         end

         if (trap_hit) begin
            // Recovery outranks any grant or release decided this cycle; rr_ptr is left alone.
            state     <= RECOVER;
            gnt       <= '0;
            core_abcd <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b1;
            rcv_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  gnt       <= '0;
                  core_abcd <= '0;
                  if (|req) begin
                     gnt      <= pick;
                     g        <= pick_idx;
                     hold_cnt <= '0;
                     busy     <= 1'b1;
                     state    <= GRANT;
                  end
               end
               GRANT: begin
                  if (release_now) begin
                     gnt       <= '0;
                     core_abcd <= '0;
                     rr_ptr    <= g;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     core_abcd <= req_abcd[{g, 2'b00} +: 4];
                     hold_cnt  <= hold_cnt + 1'b1;
                  end
               end
               RECOVER: begin
                  if (rcv_cnt == RW'(RST_CYCLES - 1)) begin
                     core_rst <= 1'b0;
                     busy     <= 1'b0;
                     trap_cnt <= '0;
                     rcv_cnt  <= '0;
                     state    <= IDLE;
                  end else begin
                     rcv_cnt <= rcv_cnt + 1'b1;
                  end
               end
               default: begin
                  gnt       <= '0;
                  core_abcd <= '0;
                  core_rst  <= 1'b1;
                  busy      <= 1'b1;
                  rcv_cnt   <= '0;
                  state     <= RECOVER;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fsm_core_arbiter.sv
// Self-checking bench for fsm_core_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural ownership model.
module tb_fsm_core_arbiter;

   localparam int NREQ       = 4;
   localparam int HOLD_MAX   = 8;
   localparam int TRAP_LIMIT = 16;
   localparam int RST_CYCLES = 2;
   localparam int OW         = NREQ + 7;

   localparam int P_IDLE = 0;
   localparam int P_OWN  = 1;
   localparam int P_RCV  = 2;

   localparam logic [OW-1:0] RESET_VEC = {{NREQ{1'b0}}, 4'b0000, 1'b1, 1'b0, 1'b1};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [4*NREQ-1:0] req_abcd = '0;
   logic [1:0]        core_out = 2'b00;
   logic              trap_clr = 1'b0;
   logic [NREQ-1:0]   gnt;
   logic [3:0]        core_abcd;
   logic              core_rst;
   logic              trap_flag;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: who owns the core, for how long, how long core_out has been stuck.
   int       m_phase;
   int       m_owner;
   int       m_held;
   int       m_streak;
   int       m_rcv;
   int       m_last;
   bit       m_flag;
   logic [3:0] m_abcd;

   fsm_core_arbiter #(
      .NREQ       (NREQ),
      .HOLD_MAX   (HOLD_MAX),
      .TRAP_LIMIT (TRAP_LIMIT),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_abcd  (req_abcd),
      .core_out  (core_out),
      .trap_clr  (trap_clr),
      .gnt       (gnt),
      .core_abcd (core_abcd),
      .core_rst  (core_rst),
      .trap_flag (trap_flag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   function automatic int first_req(logic [NREQ-1:0] r, int after);
      logic [NREQ-1:0] sh;
      for (int k = 1; k <= NREQ; k++) begin
         sh = r >> ((after + k) % NREQ);
         if (sh[0]) return (after + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(int idx);
      if (idx < 0) return '0;
      return NREQ'(1) << idx;
   endfunction

   function automatic logic [OW-1:0] obs_vec();
      return {gnt, core_abcd, core_rst, trap_flag, busy};
   endfunction

   function automatic logic [OW-1:0] exp_vec();
      return {onehot(m_owner), m_abcd, m_phase == P_RCV, m_flag, m_phase != P_IDLE};
   endfunction

   task automatic model_reset();
      m_phase  = P_RCV;
      m_owner  = -1;
      m_held   = 0;
      m_streak = 0;
      m_rcv    = 0;
      m_last   = NREQ - 1;
      m_flag   = 1'b0;
      m_abcd   = 4'h0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      logic [NREQ-1:0] sh;
      if (m_phase == P_RCV) begin
         m_rcv++;
         if (m_rcv == RST_CYCLES) begin
            m_phase  = P_IDLE;
            m_streak = 0;
         end
         if (trap_clr) m_flag = 1'b0;
         return;
      end
      if (core_out == 2'b01) m_streak = (m_streak < TRAP_LIMIT) ? m_streak + 1 : TRAP_LIMIT;
      else                   m_streak = 0;
      if (m_streak >= TRAP_LIMIT) begin
         m_phase = P_RCV;
         m_rcv   = 0;
         m_flag  = 1'b1;
         m_owner = -1;
         m_abcd  = 4'h0;
         return;
      end
      if (trap_clr) m_flag = 1'b0;
      if (m_phase == P_IDLE) begin
         m_abcd  = 4'h0;
         m_owner = first_req(req, m_last);
         if (m_owner >= 0) begin
            m_phase = P_OWN;
            m_held  = 1;
         end
      end else begin
         sh = req >> m_owner;
         if (!sh[0] || m_held == HOLD_MAX) begin
            m_last  = m_owner;
            m_owner = -1;
            m_phase = P_IDLE;
            m_abcd  = 4'h0;
         end else begin
            m_abcd = 4'(req_abcd >> (4 * m_owner));
            m_held++;
         end
      end
   endtask

   // One clock: model and DUT both see the same inputs at the edge; return at negedge.
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      req      = '0;
      core_out = 2'b00;
      trap_clr = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (m_phase == P_IDLE) break;
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (obs_vec() !== RESET_VEC) begin errors++; $display("FAIL reset_values got=%b exp=%b", obs_vec(), RESET_VEC); end
      rst_n = 1'b1;
      model_reset();
      step();
      checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_rst_hold1 got=%b exp=1", core_rst); end
      checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL reset_model1 got=%b exp=%b", obs_vec(), exp_vec()); end
      step();
      checks++; if ({core_rst, busy, gnt} !== {1'b0, 1'b0, {NREQ{1'b0}}}) begin errors++; $display("FAIL reset_release rst=%b busy=%b gnt=%b exp 0 0 0", core_rst, busy, gnt); end
   endtask

   task automatic test_arbitration();
      req = 4'b1010;
      for (int i = 1; i <= 10; i++) begin
         step();
         checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL arb_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
         if (i == 1) begin
            checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL arb_first got=%b exp=0010", gnt); end
         end
         if (i == 9) begin
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL arb_gap got=%b exp=0000", gnt); end
         end
         if (i == 10) begin
            checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL arb_second got=%b exp=1000", gnt); end
         end
      end
   endtask

   task automatic test_datapath();
      drain();
      req_abcd = 16'h93_4F;
      req      = 4'b0010;
      step();
      checks++; if ({gnt, core_abcd} !== {4'b0010, 4'b0000}) begin errors++; $display("FAIL dp_grant gnt=%b abcd=%b exp 0010 0000", gnt, core_abcd); end
      step();
      checks++; if (core_abcd !== 4'b0100) begin errors++; $display("FAIL dp_data got=%b exp=0100", core_abcd); end
      req = 4'b0000;
      step();
      checks++; if ({gnt, core_abcd} !== {4'b0000, 4'b0000}) begin errors++; $display("FAIL dp_release gnt=%b abcd=%b exp 0000 0000", gnt, core_abcd); end
      checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL dp_model got=%b exp=%b", obs_vec(), exp_vec()); end
   endtask

   task automatic test_hold_limit();
      int n;
      int cnt;
      drain();
      req = 4'b0001;
      n = 0;
      while (gnt !== 4'b0001 && n < 4) begin step(); n++; end
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL hold_first got=%b exp=0001", gnt); end
      cnt = 0;
      while (gnt === 4'b0001 && cnt < 20) begin
         cnt++;
         step();
         checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL hold_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      end
      checks++; if (cnt !== HOLD_MAX) begin errors++; $display("FAIL hold_len got=%0d exp=%0d", cnt, HOLD_MAX); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle busy=%b exp=0", busy); end
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL hold_regrant got=%b exp=0001", gnt); end
   endtask

   task automatic test_trap();
      drain();
      req = 4'b0100;
      step();
      core_out = 2'b01;
      repeat (TRAP_LIMIT - 1) begin
         step();
         checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL trap_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      end
      checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL trap_early rst=%b exp=0", core_rst); end
      step();
      checks++; if ({gnt, core_rst, trap_flag} !== {4'b0000, 1'b1, 1'b1}) begin errors++; $display("FAIL trap_fire gnt=%b rst=%b flag=%b exp 0000 1 1", gnt, core_rst, trap_flag); end
      core_out = 2'b00;
      step();
      checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL trap_rst2 got=%b exp=1", core_rst); end
      step();
      checks++; if ({core_rst, trap_flag} !== 2'b01) begin errors++; $display("FAIL trap_rst_end rst=%b flag=%b exp 0 1", core_rst, trap_flag); end
      trap_clr = 1'b1;
      step();
      trap_clr = 1'b0;
      checks++; if (trap_flag !== 1'b0) begin errors++; $display("FAIL trap_clr got=%b exp=0", trap_flag); end
   endtask

   task automatic test_collision();
      bit done;
      int saved;
      drain();
      req      = '1;
      core_out = 2'b01;
      done     = 1'b0;
      saved    = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (m_streak == TRAP_LIMIT - 1) begin
            if (m_phase == P_OWN) req = ~onehot(m_owner);
            trap_clr = 1'b1;
            saved    = m_last;
            done     = 1'b1;
         end
         step();
         checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL coll_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      end
      checks++; if (!done) begin errors++; $display("FAIL coll_timeout trap streak never reached %0d", TRAP_LIMIT - 1); end
      trap_clr = 1'b0;
      core_out = 2'b00;
      req      = '1;
      checks++; if ({gnt, core_rst, trap_flag} !== {4'b0000, 1'b1, 1'b1}) begin errors++; $display("FAIL coll_trap_wins gnt=%b rst=%b flag=%b exp 0000 1 1", gnt, core_rst, trap_flag); end
      step();
      step();
      checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL coll_recover rst=%b exp=0", core_rst); end
      step();
      checks++; if (gnt !== onehot((saved + 1) % NREQ)) begin errors++; $display("FAIL coll_rr_ptr got=%b exp=%b", gnt, onehot((saved + 1) % NREQ)); end
   endtask

   task automatic test_async_reset();
      drain();
      req_abcd = 16'h000A;
      req      = 4'b0001;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (obs_vec() !== RESET_VEC) begin errors++; $display("FAIL async_reset got=%b exp=%b", obs_vec(), RESET_VEC); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (obs_vec() !== RESET_VEC) begin errors++; $display("FAIL async_hold got=%b exp=%b", obs_vec(), RESET_VEC); end
      rst_n = 1'b1;
      model_reset();
      repeat (3) begin
         step();
         checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL async_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      end
   endtask

   task automatic test_random();
      int stuck;
      stuck = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) req = NREQ'($urandom);
         req_abcd = (4 * NREQ)'($urandom);
         if (stuck > 0) begin
            core_out = 2'b01;
            stuck--;
         end else begin
            if ($urandom_range(40) == 0) stuck = $urandom_range(20, 12);
            core_out = 2'($urandom);
         end
         trap_clr = ($urandom_range(15) == 0);
         step();
         checks++; if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec()); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_arbitration();
      test_datapath();
      test_hold_limit();
      test_trap();
      test_collision();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_core_arbiter.md
Name: fsm_core_arbiter

Overview:
- Shares one fsm_2-style core (inputs A/B/C/D, 2-bit state output) between NREQ requesters.
- Round-robin grant; the granted requester's ABCD vector is registered onto the core inputs.
- A trap monitor watches the core output for the absorbing state 2'b01 and forces a core reset after TRAP_LIMIT consecutive cycles.
- Sits between the stimulus/requester agents and the core instance; the core's clk is shared.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_MAX, 8, maximum cycles one grant may be held.
- TRAP_LIMIT, 16, consecutive cycles of core_out==2'b01 that trigger recovery.
- RST_CYCLES, 2, cycles core_rst is held high during recovery.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request, level, held while ownership is wanted.
- req_abcd  in  4*NREQ  requester i drives {A,B,C,D} on bits [4i+3:4i] (bit 4i+3=A).
- core_out  in  2  state output of the shared core.
- trap_clr  in  1  clears the sticky trap_flag.
- gnt  out  NREQ  one-hot grant, registered.
- core_abcd  out  4  {A,B,C,D} to the core, registered.
- core_rst  out  1  active-high reset to the core.
- trap_flag  out  1  sticky; set when recovery fires.
- busy  out  1  high in GRANT or RECOVER.

Behaviour:
- All state resets asynchronously on rst_n low.
- Reset values: gnt=0, core_abcd=0, trap_flag=0, busy=1, core_rst=1, rr_ptr=NREQ-1, hold_cnt=0, trap_cnt=0, rcv_cnt=0.
- Reset state is RECOVER. After rst_n rises, core_rst stays high for RST_CYCLES clocks, then the block enters IDLE.
- States: IDLE, GRANT, RECOVER.
- IDLE:
  - gnt=0, core_abcd=0, busy=0.
  - If any req is high, pick the first requester with req high, searching upward from rr_ptr+1 modulo NREQ.
  - The next cycle: gnt=onehot(g), state=GRANT, hold_cnt=0.
  - Request-to-grant latency is 1 clock.
- GRANT:
  - core_abcd <= req_abcd[g] every cycle, so the core sees requester data 1 clock after it is presented.
  - hold_cnt increments each cycle.
  - Release occurs when req[g]==0, or when hold_cnt==HOLD_MAX-1 with req[g] still high.
  - On release: gnt=0, core_abcd=0, rr_ptr=g, state=IDLE.
  - Exactly one IDLE cycle separates consecutive grants, even back-to-back.
  - A requester forced off by HOLD_MAX re-competes at lowest priority.
- Trap monitor:
  - Active in IDLE and GRANT.
  - trap_cnt increments while core_out==2'b01 and clears to 0 on any other value.
  - trap_cnt saturates at TRAP_LIMIT.
  - When trap_cnt reaches TRAP_LIMIT: state=RECOVER next cycle, gnt=0, core_abcd=0, core_rst=1, trap_flag=1, rcv_cnt=0.
- RECOVER:
  - core_rst high for RST_CYCLES cycles, then state=IDLE, trap_cnt=0.
  - req is ignored; rr_ptr is unchanged.
- Simultaneous events:
  - A trap in the same cycle as a release or grant decision wins: no grant is issued, and rr_ptr is not updated by the aborted grant.
  - trap_clr in the same cycle as a trap firing leaves trap_flag=1 (set wins).
- Mid-operation rst_n: everything returns to reset values immediately, with no wait for a clock edge.
- Widths:
  - hold_cnt is clog2(HOLD_MAX) bits.
  - trap_cnt is clog2(TRAP_LIMIT+1) bits.
  - rr_ptr is clog2(NREQ) bits, with explicit modulo wrap when NREQ is not a power of two.

Decomposition:
- Package fsm_core_pkg:
  - state enum (IDLE=2'd0, GRANT=2'd1, RECOVER=2'd2);
  - core state codes CORE_S0..CORE_S3 = 2'b00..2'b11;
  - TRAP_STATE = CORE_S1.
- Sub-module rr_pick: combinational round-robin search; inputs req and rr_ptr, outputs one-hot pick and its index.
- Everything else lives in fsm_core_arbiter.

Test Plan:
- Reset release → core_rst=1 for 2 cycles after rst_n rises, then 0; gnt=0; busy drops to 0 on entering IDLE.
- Arbitration order: req=4'b1010 held, rr_ptr=3 → gnt=0010 one clock later; after release, IDLE for 1 cycle, then gnt=1000.
- Data path: requester 1 granted with req_abcd[7:4]=4'b0100 (B=1) → core_abcd=0100 one clock later; drop req[1] → core_abcd=0000 and gnt=0 the next clock.
- Hold limit: req=4'b0001 held continuously → gnt=0001 for exactly 8 cycles, 1 IDLE cycle, then re-granted.
- Trap: hold core_out=2'b01 for 16 cycles during a grant → next cycle gnt=0, core_rst=1 for 2 cycles, trap_flag=1; trap_clr pulse → trap_flag=0.
- Trap vs. release collision, plus rst_n pulled low mid-GRANT → trap wins with rr_ptr unchanged; on rst_n low, all outputs take reset values asynchronously.
